// File: rtl/ex_result_skid_pkg.sv
// Shared CPU types for the execute-to-memory result hand-off buffer.
package ex_result_skid_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              regwrite;
        logic              zero;
        logic              neg;
    } entry_t;

endpackage

// File: rtl/ex_result_flags.sv
// Zero/negative flag derivation for an execute-stage result.
module ex_result_flags
    import ex_result_skid_pkg::*;
(
    input  logic [DATA_W-1:0] result,
    output logic              zero_c,
    output logic              neg_c
);

    // Flags follow the result combinationally; they are stored with the entry at push.
    assign zero_c = (result == '0);
    assign neg_c  = result[DATA_W-1];

endmodule

// File: rtl/ex_result_skid.sv
// Registered skid FIFO between execute and memory/writeback stages.
// Optional macro EX_RESULT_FWD_EN adds a forwarding view of the newest buffered entry.
module ex_result_skid
    import ex_result_skid_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_reg_write,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_reg_write,
    output logic              out_zero,
    output logic              out_neg
`ifdef EX_RESULT_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_result
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic               in_zero_c;
    logic               in_neg_c;
    entry_t             in_entry;
    entry_t             head_c;

    ex_result_flags u_flags (
        .result (in_result),
        .zero_c (in_zero_c),
        .neg_c  (in_neg_c)
    );

    // Handshake status comes from registered count only.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Assemble the entry to store, flags included.
    always_comb begin
        in_entry          = '0;
        in_entry.result   = in_result;
        in_entry.rd       = in_rd;
        in_entry.regwrite = in_reg_write;
        in_entry.zero     = in_zero_c;
        in_entry.neg      = in_neg_c;
    end

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is written only on an accepted push; contents survive flush.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_entry;
    end

    // Head entry, forced to zero while empty.
    always_comb begin
        head_c = '0;
        if (out_valid) head_c = mem[rd_ptr];
    end

    assign out_result    = head_c.result;
    assign out_rd        = head_c.rd;
    assign out_reg_write = head_c.regwrite;
    assign out_zero      = head_c.zero;
    assign out_neg       = head_c.neg;

`ifdef EX_RESULT_FWD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Newest buffered entry sits just behind the write pointer.
    always_comb begin
        fwd_idx    = wr_ptr - PTR_W'(1);
        fwd_valid  = 1'b0;
        fwd_rd     = '0;
        fwd_result = '0;
        if (out_valid) begin
            fwd_valid  = mem[fwd_idx].regwrite;
            fwd_rd     = mem[fwd_idx].rd;
            fwd_result = mem[fwd_idx].result;
        end
    end
`else
    // No forwarding view in this build.
`endif

endmodule

// File: tb/tb_ex_result_skid.sv
// Scoreboard bench for ex_result_skid; forwarding checks compile in with EX_RESULT_FWD_EN.
module tb_ex_result_skid;
    import ex_result_skid_pkg::*;

    logic              clock;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic [REG_W-1:0]  in_rd;
    logic              in_reg_write;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [REG_W-1:0]  out_rd;
    logic              out_reg_write;
    logic              out_zero;
    logic              out_neg;
`ifdef EX_RESULT_FWD_EN
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_rd;
    logic [DATA_W-1:0] fwd_result;
`endif

    int     checks = 0;
    int     errors = 0;
    entry_t sb[$];

    ex_result_skid #(.DEPTH(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_rd         (in_rd),
        .in_reg_write  (in_reg_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_rd        (out_rd),
        .out_reg_write (out_reg_write),
        .out_zero      (out_zero),
        .out_neg       (out_neg)
`ifdef EX_RESULT_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_result    (fwd_result)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: head must match the scoreboard front; pop it on a handshake.
    always @(negedge clock) begin
        if (reset && out_valid) begin
            entry_t got;
            got = '{result: out_result, rd: out_rd, regwrite: out_reg_write,
                    zero: out_zero, neg: out_neg};
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got 0x%0h with empty scoreboard at %0t", got, $time);
            end else begin
                chk("head_entry", 32'(got), 32'(sb[0]));
                if (out_ready && !flush) void'(sb.pop_front());
            end
        end
    end

    // One push attempt; caller starts just after a rising edge.
    task automatic push_once(input entry_t v, output bit acc);
        in_valid     = 1'b1;
        in_result    = v.result;
        in_rd        = v.rd;
        in_reg_write = v.regwrite;
        @(negedge clock);
        acc = in_ready;
        @(posedge clock);
        if (acc) sb.push_back(v);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_hold(input entry_t v);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 20; k++) begin
            push_once(v, acc);
            if (acc) break;
        end
        chk("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            if (sb.size() == 0 && !out_valid) break;
        end
        chk("drain_scoreboard", 32'(sb.size()), 32'd0);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic chk_empty_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_result"}, 32'(out_result), 32'd0);
        chk({tag, "_out_rd"}, 32'(out_rd), 32'd0);
        chk({tag, "_out_reg_write"}, 32'(out_reg_write), 32'd0);
        chk({tag, "_out_zero"}, 32'(out_zero), 32'd0);
        chk({tag, "_out_neg"}, 32'(out_neg), 32'd0);
`ifdef EX_RESULT_FWD_EN
        chk({tag, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
        chk({tag, "_fwd_rd"}, 32'(fwd_rd), 32'd0);
        chk({tag, "_fwd_result"}, 32'(fwd_result), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        entry_t v;
        reset        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_result    = '0;
        in_rd        = '0;
        in_reg_write = 1'b0;
        out_ready    = 1'b0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk_empty_outputs("reset");
        @(posedge clock);
        #1;

        // Single pass: 0x8000 >>> 3 = 0xF000, negative, nonzero
        out_ready = 1'b1;
        push_hold('{result: 16'hF000, rd: 4'd5, regwrite: 1'b1, zero: 1'b0, neg: 1'b1});
        @(negedge clock);
        chk("single_out_valid", 32'(out_valid), 32'd1);
        chk("single_out_neg", 32'(out_neg), 32'd1);
        @(negedge clock);
        chk("single_after_pop", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;

        // Zero flag
        push_hold('{result: 16'h0000, rd: 4'd3, regwrite: 1'b0, zero: 1'b1, neg: 1'b0});
        @(negedge clock);
        chk("zero_flag", 32'(out_zero), 32'd1);
        drain();

        // Fill and backpressure
        out_ready = 1'b0;
        push_hold('{result: 16'h0001, rd: 4'd1, regwrite: 1'b1, zero: 1'b0, neg: 1'b0});
        push_hold('{result: 16'h0002, rd: 4'd2, regwrite: 1'b0, zero: 1'b0, neg: 1'b0});
        fork
            push_hold('{result: 16'h0003, rd: 4'd3, regwrite: 1'b1, zero: 1'b0, neg: 1'b0});
            begin
                @(negedge clock);
                chk("full_in_ready", 32'(in_ready), 32'd0);
                chk("full_head_hold", 32'(out_result), 32'h0001);
                @(negedge clock);
                chk("full_in_ready_2", 32'(in_ready), 32'd0);
                chk("full_head_stable", 32'(out_result), 32'h0001);
                @(posedge clock);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Simultaneous push/pop at occupancy 1, pointers wrap repeatedly
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = '{result: 16'h0010 + 16'(i), rd: 4'(i), regwrite: 1'(i % 2),
                  zero: 1'b0, neg: 1'b0};
            in_valid     = 1'b1;
            in_result    = v.result;
            in_rd        = v.rd;
            in_reg_write = v.regwrite;
            @(negedge clock);
            if (i > 0) begin
                chk("stream_out_valid", 32'(out_valid), 32'd1);
                chk("stream_in_ready", 32'(in_ready), 32'd1);
            end
            acc = in_ready;
            @(posedge clock);
            if (acc) sb.push_back(v);
            chk("stream_accepted", 32'(acc), 32'd1);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Flush while full, with a simultaneous input offer
        out_ready = 1'b0;
        push_hold('{result: 16'h0021, rd: 4'd1, regwrite: 1'b1, zero: 1'b0, neg: 1'b0});
        push_hold('{result: 16'h0022, rd: 4'd2, regwrite: 1'b1, zero: 1'b0, neg: 1'b0});
`ifdef EX_RESULT_FWD_EN
        @(negedge clock);
        chk("fwd_newest_result", 32'(fwd_result), 32'h0022);
        chk("fwd_newest_valid", 32'(fwd_valid), 32'd1);
        @(posedge clock);
        #1;
`endif
        in_valid  = 1'b1;
        in_result = 16'h00AA;
        in_rd     = 4'd10;
        flush     = 1'b1;
        @(posedge clock);
        sb.delete();
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk_empty_outputs("flush_full");
        @(posedge clock);
        #1;

        // Flush at occupancy 1 while the input would otherwise be accepted
        push_hold('{result: 16'h0023, rd: 4'd3, regwrite: 1'b1, zero: 1'b0, neg: 1'b0});
        in_valid  = 1'b1;
        in_result = 16'h00AB;
        flush     = 1'b1;
        @(posedge clock);
        sb.delete();
        #1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk_empty_outputs("flush_one");
        repeat (3) @(posedge clock);
        #1;
        chk("flush_stays_empty", 32'(out_valid), 32'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        push_hold('{result: 16'h0031, rd: 4'd7, regwrite: 1'b1, zero: 1'b0, neg: 1'b0});
`ifdef EX_RESULT_FWD_EN
        @(negedge clock);
        chk("fwd_pre_reset_valid", 32'(fwd_valid), 32'd1);
        chk("fwd_pre_reset_rd", 32'(fwd_rd), 32'd7);
        @(posedge clock);
        #1;
`endif
        reset = 1'b0;
        @(posedge clock);
        sb.delete();
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk_empty_outputs("mid_reset");
        @(posedge clock);
        #1;

        // Normal operation resumes after reset
        out_ready = 1'b1;
        push_hold('{result: 16'h8001, rd: 4'd15, regwrite: 1'b1, zero: 1'b0, neg: 1'b1});
        push_hold('{result: 16'h0000, rd: 4'd0, regwrite: 1'b1, zero: 1'b1, neg: 1'b0});
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_result_skid.md
Name: ex_result_skid

Overview:
- Registered hand-off buffer between the execute stage (ALU and shifter outputs, including arithmetic right shift) and the memory/writeback stage of the 16-bit CPU.
- Captures each result with its destination register and write-enable, and derives zero/negative flags from the result.
- Uses a valid/ready handshake so the execute stage can stall cleanly when memory backs up.
- Acts as a small FIFO (skid buffer) so a downstream stall never drops a result.

Parameters:
- DATA_W, 16, width of the result word.
- REG_W, 4, width of the destination register index.
- DEPTH, 2, number of buffered entries; must be a power of two, 2 or greater.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- Flush  input  1  synchronous discard of all buffered entries (branch/exception).
- InValid  input  1  execute stage presents a result.
- InReady  output  1  buffer can accept an entry this cycle.
- InResult  input  DATA_W  ALU/shifter result.
- InRd  input  REG_W  destination register index.
- InRegWrite  input  1  result must be written to the register file.
- OutValid  output  1  head entry valid.
- OutReady  input  1  downstream consumes the head entry this cycle.
- OutResult  output  DATA_W  head entry result.
- OutRd  output  REG_W  head entry destination.
- OutRegWrite  output  1  head entry write-enable.
- OutZero  output  1  head entry result equals 0.
- OutNeg  output  1  head entry result MSB.

Behaviour:
- Reset (Reset low at a rising edge):
  - Read pointer, write pointer and count go to 0.
  - OutValid = 0, InReady = 1.
  - OutResult, OutRd, OutRegWrite, OutZero and OutNeg read 0.
- Push: InValid && InReady at an edge. The entry is written at the write pointer, and the write pointer increments modulo DEPTH (natural wrap).
- Pop: OutValid && OutReady at an edge. The read pointer increments modulo DEPTH.
- Flags are computed once, at push time, and stored with the entry:
  - Zero = (InResult == 0).
  - Neg = InResult[DATA_W-1].
- Count:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- InReady = (count != DEPTH). It is derived from registered count only and never depends combinationally on OutReady.
- OutValid = (count != 0). Out* fields are driven from the entry at the read pointer; they are 0 when empty.
- Latency: an entry accepted at edge N is visible on Out* after edge N, i.e. one cycle. There is no combinational pass-through.
- Full (count == DEPTH):
  - InReady = 0; InValid is ignored and the upstream holds its data.
  - A pop that cycle raises InReady on the next cycle.
- Empty (count == 0): OutReady is ignored. A push that cycle gives OutValid = 1 on the next cycle.
- Flush:
  - Clears pointers and count at the edge and takes precedence over push and pop in the same cycle; the flushed-cycle input is discarded.
  - Storage contents need not be cleared.
- Reset dominates Flush. Reset mid-stream drops all entries.
- Data in storage is only written on push. Out* are stable while OutValid && !OutReady.

Optional Feature:
- Macro: EX_RESULT_FWD_EN.
- With the macro, three extra outputs are added for the hazard/forwarding unit:
  - FwdValid (1 bit).
  - FwdRd (REG_W bits).
  - FwdResult (DATA_W bits).
  - They expose the most recently pushed, still-buffered entry (at write pointer - 1, modulo DEPTH).
  - FwdValid = (count != 0) && that entry's RegWrite.
  - All three are 0 after reset or flush.
- Without the macro, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared CPU package holds:
  - DATA_W = 16 and REG_W = 4 constants.
  - A packed entry typedef {result, rd, regwrite, zero, neg}.
- One natural sub-module, ex_result_flags, computes zero/neg combinationally from the result; it is instantiated at the push side.
- The pointer/count FIFO logic stays in the top module.

Test Plan:
- Single pass:
  - Stimulus: reset, then push InResult = 0xF000 (0x8000 shifted right arithmetically by 3), InRd = 5, InRegWrite = 1, with OutReady = 1.
  - Response: the next cycle shows OutValid = 1, OutResult = 0xF000, OutRd = 5, OutNeg = 1, OutZero = 0. OutValid drops after the pop.
- Zero flag: push 0x0000 -> OutZero = 1, OutNeg = 0.
- Fill and backpressure:
  - Stimulus: OutReady = 0; push 0x0001, then 0x0002; hold 0x0003 valid.
  - Response: InReady = 0 after the second push and 0x0003 is not accepted. Raise OutReady: the order out is 0x0001, 0x0002, then 0x0003.
- Simultaneous push/pop at count 1 for 8 cycles with values 0x0010..0x0017 -> count stays 1, the outputs appear in order, and the pointers wrap correctly.
- Flush:
  - Stimulus: with 2 entries held, assert Flush together with InValid (0x00AA).
  - Response: the next cycle shows OutValid = 0 and InReady = 1, and 0x00AA never appears.
- Reset mid-stream: with 1 entry held, Reset = 0 for one cycle -> OutValid = 0 and all Out* = 0. With EX_RESULT_FWD_EN, FwdValid = 0.
